// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, taken-branch
// redirects and data-memory waits, with a memory watchdog and a debug stall counter.
module pipeline_hazard_ctrl #(
   parameter int PC_WIDTH    = 64,
   parameter int CNT_WIDTH   = 32,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [4:0]           id_rs1,
   input  logic [4:0]           id_rs2,
   input  logic                 id_uses_rs1,
   input  logic                 id_uses_rs2,
   input  logic [4:0]           ex_rd,
   input  logic                 ex_mem_read,
   input  logic                 ex_branch_taken,
   input  logic [PC_WIDTH-1:0]  ex_target,
   input  logic                 dmem_req,
   input  logic                 dmem_ready,
   output logic                 pc_stall,
   output logic                 if_id_stall,
   output logic                 if_id_flush,
   output logic                 id_ex_flush,
   output logic                 pipe_freeze,
   output logic                 pc_redirect,
   output logic [PC_WIDTH-1:0]  pc_redirect_target,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic                 mem_timeout_err
);

   localparam logic [1:0]  ST_RUN       = 2'd0;
   localparam logic [1:0]  ST_LU_BUBBLE = 2'd1;
   localparam logic [1:0]  ST_MEM_WAIT  = 2'd2;
   localparam logic [15:0] WAIT_MAX     = 16'(MEM_TIMEOUT);
   localparam logic [15:0] WAIT_LAST    = 16'(MEM_TIMEOUT - 1);

   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic [15:0]          wait_cnt_r;
   logic [CNT_WIDTH-1:0] stall_count_r;
   logic                 mem_timeout_err_r;
   logic                 rs1_hit_s;
   logic                 rs2_hit_s;
   logic                 load_use_s;
   logic                 mem_wait_s;
   logic                 branch_s;
   logic                 lu_allowed_s;
   logic                 stall_s;
   logic                 if_id_flush_s;
   logic                 id_ex_flush_s;
   logic                 freeze_s;
   logic                 redirect_s;

   // Hazard terms; rst_n gates every input so all controls read 0 while in reset.
   always_comb begin
      rs1_hit_s  = id_uses_rs1 && (id_rs1 == ex_rd);
      rs2_hit_s  = id_uses_rs2 && (id_rs2 == ex_rd);
      load_use_s = rst_n && ex_mem_read && (ex_rd != 5'd0) && (rs1_hit_s || rs2_hit_s);
      mem_wait_s = rst_n && dmem_req && !dmem_ready;
      branch_s   = rst_n && ex_branch_taken;
   end

   // Control decode and next state; the load has left EX in the bubble cycle, so load_use is ignored there.
   always_comb begin
      stall_s       = 1'b0;
      if_id_flush_s = 1'b0;
      id_ex_flush_s = 1'b0;
      freeze_s      = 1'b0;
      redirect_s    = 1'b0;
      state_nxt_s   = ST_RUN;
      case (state_r)
         ST_RUN:       lu_allowed_s = 1'b1;
         ST_LU_BUBBLE: lu_allowed_s = 1'b0;
         ST_MEM_WAIT:  lu_allowed_s = 1'b1;
         default:      lu_allowed_s = 1'b1;
      endcase
      if (mem_wait_s) begin
         stall_s     = 1'b1;
         freeze_s    = 1'b1;
         state_nxt_s = ST_MEM_WAIT;
      end else if (branch_s) begin
         redirect_s    = 1'b1;
         if_id_flush_s = 1'b1;
         id_ex_flush_s = 1'b1;
         state_nxt_s   = ST_RUN;
      end else if (load_use_s && lu_allowed_s) begin
         stall_s       = 1'b1;
         id_ex_flush_s = 1'b1;
         state_nxt_s   = ST_LU_BUBBLE;
      end else begin
         state_nxt_s = ST_RUN;
      end
   end

   assign pc_stall           = stall_s;
   assign if_id_stall        = stall_s;
   assign if_id_flush        = if_id_flush_s;
   assign id_ex_flush        = id_ex_flush_s;
   assign pipe_freeze        = freeze_s;
   assign pc_redirect        = redirect_s;
   assign pc_redirect_target = rst_n ? ex_target : {PC_WIDTH{1'b0}};
   assign stall_count        = stall_count_r;
   assign mem_timeout_err    = mem_timeout_err_r;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Watchdog: counts consecutive memory-wait cycles, saturating; any cycle without a wait clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_r <= 16'd0;
      end else if (!mem_wait_s) begin
         wait_cnt_r <= 16'd0;
      end else if (wait_cnt_r != WAIT_MAX) begin
         wait_cnt_r <= wait_cnt_r + 16'd1;
      end else begin
         wait_cnt_r <= wait_cnt_r;
      end
   end

   // Sticky timeout flag, raised on the edge that brings the wait count to MEM_TIMEOUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_timeout_err_r <= 1'b0;
      end else if (mem_wait_s && (wait_cnt_r >= WAIT_LAST)) begin
         mem_timeout_err_r <= 1'b1;
      end else begin
         mem_timeout_err_r <= mem_timeout_err_r;
      end
   end

   // Saturating count of stalled cycles for debug.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_count_r <= {CNT_WIDTH{1'b0}};
      end else if (stall_s && (stall_count_r != {CNT_WIDTH{1'b1}})) begin
         stall_count_r <= stall_count_r + CNT_WIDTH'(1);
      end else begin
         stall_count_r <= stall_count_r;
      end
   end

endmodule

// Invariant checker for the hazard controller outputs.
module pipeline_hazard_ctrl_chk (
   input logic clk,
   input logic rst_n,
   input logic pc_stall,
   input logic if_id_stall,
   input logic if_id_flush,
   input logic id_ex_flush,
   input logic pipe_freeze,
   input logic pc_redirect
);

   a_stall_pair : assert property (@(posedge clk) disable iff (!rst_n) pc_stall == if_id_stall);
   a_if_id_excl : assert property (@(posedge clk) disable iff (!rst_n) !(if_id_stall && if_id_flush));
   a_id_ex_excl : assert property (@(posedge clk) disable iff (!rst_n) !(pipe_freeze && id_ex_flush));
   a_redirect   : assert property (@(posedge clk) disable iff (!rst_n) pc_redirect |-> (if_id_flush && id_ex_flush));
   a_pc_excl    : assert property (@(posedge clk) disable iff (!rst_n) !(pc_stall && pc_redirect));

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the five-stage pipeline.
- Drives the stall and flush controls of the PC register, the IF/ID register and the ID/EX register, plus the PC redirect on a taken branch.
- Inputs: decode-stage source registers, execute-stage load/branch information, and the data-memory handshake.
- A small FSM sequences load-use bubbles and memory waits. A watchdog and a stall counter support debug.

Parameters:
PC_WIDTH, 64, width of PC and redirect target
CNT_WIDTH, 32, width of the stall-cycle counter (saturating)
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_timeout_err is set (1..2^16-1)

Ports:
clk  in  1  pipeline clock, all state on rising edge
rst_n  in  1  asynchronous, active-low reset
id_rs1  in  5  rs1 of instruction in ID
id_rs2  in  5  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  destination register of instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_branch_taken  in  1  EX resolved a taken branch/jump this cycle
ex_target  in  PC_WIDTH  resolved target address
dmem_req  in  1  MEM stage issuing a data access this cycle
dmem_ready  in  1  data memory completes access this cycle
pc_stall  out  1  hold PC register
if_id_stall  out  1  hold IF/ID register
if_id_flush  out  1  load NOP into IF/ID (PC 0, instruction 0x00000013)
id_ex_flush  out  1  insert bubble into ID/EX
pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB registers
pc_redirect  out  1  load PC from pc_redirect_target
pc_redirect_target  out  PC_WIDTH  equals ex_target
stall_count  out  CNT_WIDTH  saturating count of cycles with pc_stall=1
mem_timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset state (rst_n=0, asynchronous):
  - state=RUN; stall_count=0; mem_timeout_err=0; wait counter=0.
  - Combinational outputs are evaluated as for state RUN with all inputs gated to 0: every control output is 0 and pc_redirect_target=0.
  - Reset deasserting mid-wait or mid-bubble resumes in RUN; no pending event is remembered.
- Hazard terms (combinational):
  - load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - mem_wait = dmem_req & !dmem_ready.
- Priority within a cycle: mem_wait > ex_branch_taken > load_use.
- FSM states: RUN, LU_BUBBLE, MEM_WAIT.
- RUN:
  - mem_wait: pc_stall=if_id_stall=pipe_freeze=1; no flush; no redirect. Next state MEM_WAIT. A simultaneous branch is not acted on; it is re-presented when the freeze lifts, because EX is held.
  - else ex_branch_taken: pc_redirect=1, if_id_flush=1, id_ex_flush=1, zero stalls. Next state RUN. A concurrent load_use is discarded because the ID instruction is squashed.
  - else load_use: pc_stall=if_id_stall=1, id_ex_flush=1. Next state LU_BUBBLE.
  - else: all controls 0.
- LU_BUBBLE:
  - Lasts exactly one cycle. The load has now moved to MEM, so the hazard is never re-fired for the same pair: load_use is ignored in this state.
  - Controls 0 unless mem_wait or ex_branch_taken, which are handled as in RUN.
  - Next state RUN, or MEM_WAIT if mem_wait.
- MEM_WAIT:
  - pc_stall=if_id_stall=pipe_freeze=1 every cycle while mem_wait.
  - On dmem_ready=1: controls follow the RUN rules for that same cycle, with dmem counted as ready. Zero extra latency: the pipeline advances in the ready cycle. Next state per RUN rules.
  - Wait counter increments each MEM_WAIT cycle. When it reaches MEM_TIMEOUT, mem_timeout_err is set (sticky until reset). The stall is kept; the counter saturates. The counter clears on leaving MEM_WAIT.
- Invariants:
  - pc_stall==if_id_stall always.
  - Stall and flush are never asserted together on the same register.
  - pc_redirect implies if_id_flush & id_ex_flush.
- stall_count increments on every rising edge where pc_stall=1 and saturates at all-ones.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for 1 cycle, then the load leaves EX -> cycle 0: pc_stall=if_id_stall=id_ex_flush=1; cycle 1: all 0; stall_count=1.
- x0 and no-use filter: ex_rd=0 with a matching rs1, or id_uses_rs2=0 with id_rs2==ex_rd -> no stall, stall_count stays 0.
- Taken branch with concurrent load_use: ex_branch_taken=1, ex_target=0x80000040 -> same cycle: pc_redirect=1, pc_redirect_target=0x80000040, if_id_flush=id_ex_flush=1, pc_stall=0; next cycle all 0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> pipe_freeze and pc_stall high 3 cycles, low in the ready cycle; stall_count=3; mem_timeout_err=0.
- Watchdog: MEM_TIMEOUT=4, dmem_ready held 0 for 6 cycles -> mem_timeout_err rises after the 4th wait cycle and stays 1 after dmem_ready=1, until rst_n=0.
- Async reset: assert rst_n=0 mid-MEM_WAIT between clock edges -> all outputs 0 immediately; after release with dmem_req=0, state=RUN and no stall.
